// File: rtl/xdiv_serial_pkg.sv
// Shared definitions for the serial restoring divider: state encoding and
// step-counter sizing derived from the operand width.
package xdiv_serial_pkg;

    typedef enum logic {
        XDIV_IDLE = 1'b0,
        XDIV_RUN  = 1'b1
    } xdiv_state_e;

    // Counter must reach DATA_W, the extra final cycle after the last step.
    function automatic int xdiv_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/xdiv_serial.sv
// Serial unsigned restoring divider, one quotient bit per clock.
// Shares the start/done handshake with the shift-add multiplier.
module xdiv_serial
    import xdiv_serial_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = xdiv_cnt_w(DATA_W);

    xdiv_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dsr;
    logic [DATA_W-1:0] quo;
    logic [DATA_W:0]   rem;

    logic [DATA_W+1:0] rem_sh;
    logic [DATA_W+1:0] trial;
    logic              trial_neg;

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
    // The extra top bit of rem_sh keeps the trial sign unambiguous.
    always_comb begin
        rem_sh    = {rem, quo[DATA_W-1]};
        trial     = rem_sh - {2'b00, dsr};
        trial_neg = trial[DATA_W+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= XDIV_IDLE;
            done  <= 1'b1;
            cnt   <= '0;
            dsr   <= '0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                XDIV_IDLE: begin
                    if (start) begin
                        dsr   <= divisor;
                        quo   <= dividend;
                        rem   <= '0;
                        cnt   <= '0;
                        done  <= 1'b0;
                        state <= XDIV_RUN;
                    end
                end
                XDIV_RUN: begin
                    if (cnt == CNT_W'(DATA_W)) begin
                        done  <= 1'b1;
                        state <= XDIV_IDLE;
                    end else begin
                        rem <= trial_neg ? rem_sh[DATA_W:0] : trial[DATA_W:0];
                        quo <= {quo[DATA_W-2:0], ~trial_neg};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    done  <= 1'b1;
                    state <= XDIV_IDLE;
                end
            endcase
        end
    end

    assign quotient  = quo;
    assign remainder = rem[DATA_W-1:0];

endmodule

// File: tb/tb_xdiv_serial.sv
// Directed and random checks of xdiv_serial against integer / and %.
module tb_xdiv_serial;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int vectors     = 0;
    int miscompares = 0;

    xdiv_serial #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts edges until done is seen high, bounded so a stuck DUT still ends.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 100);
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk({tag, "_busy"}, W'(done), W'(0));
        wait_done(n);
        chk({tag, "_lat"}, W'(n), W'(W + 1));
        chk({tag, "_q"}, quotient, ref_q(a, b));
        chk({tag, "_r"}, remainder, ref_r(a, b));
    endtask

    logic [W-1:0] ta [100];
    logic [W-1:0] tb [100];

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_done", W'(done), W'(1));
        chk("rst_q", quotient, '0);
        chk("rst_r", remainder, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_done", W'(done), W'(1));

        run_div("d100_7", 32'd100, 32'd7);
        run_div("max_1", 32'hFFFF_FFFF, 32'd1);
        run_div("d5_9", 32'd5, 32'd9);

        // Results must hold while idle even with inputs wandering.
        repeat (3) begin
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
        end
        chk("hold_q", quotient, 32'd0);
        chk("hold_r", remainder, 32'd5);

        run_div("div0", 32'd1234, 32'd0);

        // start pulsed mid-run with other operands must be ignored.
        start    = 1'b1;
        dividend = 32'd1000000;
        divisor  = 32'd37;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd999;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_busy", W'(done), W'(0));
        wait_done(n);
        chk("ign_lat", W'(n), W'(W + 1 - 6));
        chk("ign_q", quotient, ref_q(32'd1000000, 32'd37));
        chk("ign_r", remainder, ref_r(32'd1000000, 32'd37));

        // Asynchronous reset in the middle of a division.
        start    = 1'b1;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_done", W'(done), W'(1));
        chk("arst_q", quotient, '0);
        chk("arst_r", remainder, '0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_idle", W'(done), W'(1));

        // Back-to-back with start held high.
        for (int i = 0; i < 100; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom >> $urandom_range(0, 31);
            if (i % 17 == 3) tb[i] = '0;
            if (i % 13 == 5) ta[i] = tb[i];
        end
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dividend = ta[i];
            divisor  = tb[i];
            @(posedge clk);
            #1;
            dividend = $urandom;
            divisor  = $urandom;
            chk("b2b_busy", W'(done), W'(0));
            wait_done(n);
            chk("b2b_lat", W'(n), W'(W + 1));
            chk("b2b_q", quotient, ref_q(ta[i], tb[i]));
            chk("b2b_r", remainder, ref_r(ta[i], tb[i]));
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
